// File: rtl/io_pkg.sv
// Shared constants for the core I/O blocks: core bus width and reference clock rate.
package io_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int CLK_HZ     = 16_000_000;

    // Cycles in a given number of milliseconds at CLK_HZ.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction
endpackage

// File: rtl/input_port_debounce_bit.sv
// One pin: 2-flop synchroniser, then a counter that accepts a new level after DEBOUNCE_CYCLES edges.
// Level latency is 2 + DEBOUNCE_CYCLES edges. o_rise is a registered pulse in the same cycle as the new level.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 160_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s0_q;
    logic          s1_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronised pin disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s1_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s1_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s0_q     <= i_pin;
            s1_q     <= s0_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;
endmodule

// File: rtl/input_port.sv
// Debounced input pins with sticky rising-edge flags, read by the core as one 16-bit word.
// Read clears pending on the sampling edge; an edge accepted on that same edge survives the clear.
module input_port
    import io_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 160_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH-1:0]      i_pins,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [WIDTH-1:0]      o_level,
    output logic [WIDTH-1:0]      o_rise,
    output logic                  o_pending
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] pending;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_pin  (i_pins[g]),
            .o_level(level[g]),
            .o_rise (rise[g])
        );
    end

    // The registered rise pulse coincides with the new level, so folding it in here makes
    // the pending flag visible in that same cycle; pending_q then holds it afterwards.
    assign pending   = pending_q | rise;
    assign pending_d = i_rd ? '0 : pending;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        o_data              = '0;
        o_data[2*WIDTH-1:0] = {pending, level};
    end

    assign o_level   = level;
    assign o_rise    = rise;
    assign o_pending = |pending;
endmodule

// File: tb/tb_input_port.sv
// Directed stimulus for input_port (WIDTH=3, DEBOUNCE_CYCLES=4) with a queue-based scoreboard.
module tb_input_port;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_pins;
    logic        i_rd;
    logic [15:0] o_data;
    logic [2:0]  o_level;
    logic [2:0]  o_rise;
    logic        o_pending;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  level;
        logic [2:0]  rise;
        logic        pend;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    input_port #(
        .WIDTH(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pins   (i_pins),
        .i_rd     (i_rd),
        .o_data   (o_data),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic expect_now(input string nm, input logic [15:0] d, input logic [2:0] lv,
                              input logic [2:0] rs, input logic p);
        exp_t e;
        e.data  = d;
        e.level = lv;
        e.rise  = rs;
        e.pend  = p;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic rd_pulse();
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge i_clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (o_data !== e.data || o_level !== e.level || o_rise !== e.rise ||
                    o_pending !== e.pend) begin
                    fails++;
                    $display("FAIL %s: got data=%h level=%b rise=%b pend=%b, want data=%h level=%b rise=%b pend=%b",
                             nm, o_data, o_level, o_rise, o_pending,
                             e.data, e.level, e.rise, e.pend);
                end
            end
        end
    end

    initial begin
        i_rst  = 1'b1;
        i_pins = 3'b000;
        i_rd   = 1'b0;
        #1;
        expect_now("reset", 16'h0000, 3'b000, 3'b000, 1'b0);
        tick(2);
        i_rst = 1'b0;
        tick(1);
        expect_now("idle", 16'h0000, 3'b000, 3'b000, 1'b0);

        // Clean step on pin 0: accepted on the 6th edge.
        i_pins = 3'b001;
        tick(5);
        expect_now("step_pre", 16'h0000, 3'b000, 3'b000, 1'b0);
        tick(1);
        expect_now("step_acc", 16'h0009, 3'b001, 3'b001, 1'b1);
        tick(1);
        expect_now("step_hold", 16'h0009, 3'b001, 3'b000, 1'b1);

        // Three-cycle glitch on pin 1 is discarded.
        i_pins = 3'b011;
        tick(3);
        i_pins = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            expect_now("glitch", 16'h0009, 3'b001, 3'b000, 1'b1);
        end

        rd_pulse();
        expect_now("rd_clear", 16'h0001, 3'b001, 3'b000, 1'b0);

        // Four-cycle high on pin 1 is accepted; its later fall gives no pulse.
        i_pins = 3'b011;
        tick(4);
        i_pins = 3'b001;
        tick(2);
        expect_now("p1_acc", 16'h0013, 3'b011, 3'b010, 1'b1);
        tick(3);
        expect_now("p1_hold", 16'h0013, 3'b011, 3'b000, 1'b1);
        tick(1);
        expect_now("p1_fall", 16'h0011, 3'b001, 3'b000, 1'b1);
        rd_pulse();
        expect_now("p1_clear", 16'h0001, 3'b001, 3'b000, 1'b0);

        // Pin 2 acceptance lands on the same edge as a read: the set wins.
        i_pins = 3'b101;
        tick(5);
        expect_now("simul_pre", 16'h0001, 3'b001, 3'b000, 1'b0);
        rd_pulse();
        expect_now("simul", 16'h0025, 3'b101, 3'b100, 1'b1);
        tick(1);
        expect_now("simul_hold", 16'h0025, 3'b101, 3'b000, 1'b1);
        rd_pulse();
        expect_now("simul_clear", 16'h0005, 3'b101, 3'b000, 1'b0);

        // Asynchronous reset two cycles into a pin 0 change.
        i_pins = 3'b100;
        tick(2);
        i_rst = 1'b1;
        expect_now("rst_mid", 16'h0000, 3'b000, 3'b000, 1'b0);
        tick(1);
        expect_now("rst_held", 16'h0000, 3'b000, 3'b000, 1'b0);
        i_pins = 3'b001;
        i_rst  = 1'b0;
        tick(5);
        expect_now("post_rst_pre", 16'h0000, 3'b000, 3'b000, 1'b0);
        tick(1);
        expect_now("post_rst_acc", 16'h0009, 3'b001, 3'b001, 1'b1);

        tick(2);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_port.md
# input_port

Debounced, edge-latching input port feeding external pins into `core`; the input counterpart of the top-level pin/LED output path. Each pin is synchronised into the `i_clk` domain and debounced with a per-bit counter. The block also records rising edges in sticky pending bits. The core reads stable levels and pending edges as one 16-bit word, and a read clears the pending bits.

## Interface
- `WIDTH`, default 3: number of input pins, 1..8.
- `DEBOUNCE_CYCLES`, default 160_000 (10 ms at 16 MHz): consecutive cycles a new level must persist before it is accepted, ≥2.
- `i_clk`  in  1: core clock; all state on rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_pins`  in  WIDTH: raw asynchronous pin levels.
- `i_rd`  in  1: read strobe, one cycle per read; clears pending bits at the sampling edge.
- `o_data`  out  16: `{pending[WIDTH-1:0], level[WIDTH-1:0]}` in bits [2*WIDTH-1:0]; upper bits 0.
- `o_level`  out  WIDTH: debounced stable levels.
- `o_rise`  out  WIDTH: one-cycle pulse per accepted 0→1 transition.
- `o_pending`  out  1: OR of all pending bits (interrupt/poll flag).

## Operation
- Per bit: 2-flop synchroniser (`s0`→`s1`), then a debounce counter against `stable`.
- If `s1 != stable`: counter increments. On the edge where the counter equals `DEBOUNCE_CYCLES-1`, `stable <= s1` and the counter returns to 0.
- If `s1 == stable`: counter is 0 on the next edge. Any glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- `o_rise[i]` is registered. It is 1 for exactly the cycle following the edge where `stable[i]` went 0→1, otherwise 0. A 1→0 transition produces no pulse.
- `pending[i]` is set on the same edge that `stable[i]` goes 0→1. It is cleared on an edge where `i_rd`=1.
- Set and clear on the same edge: set wins, so the new edge is never lost.
- `o_data` and `o_pending` are combinational from registered `pending`/`stable`. The core samples `o_data` in the same cycle it asserts `i_rd`.
- `i_rd` held high for several cycles clears repeatedly. This is harmless; only newly set bits survive each edge.

## Timing
- Reset: `s0`, `s1`, `stable`, counters, `pending`, and `o_rise` are 0, so `o_data`=0, `o_level`=0, `o_rise`=0, and `o_pending`=0.
- Reset is asserted asynchronously and released synchronously by the top level. Reset mid-count discards the partial count.
- Pin-to-level latency for a clean step is 2 + `DEBOUNCE_CYCLES` cycles: 2 synchroniser edges plus N counting edges.
- `o_rise` and `pending` are visible in the same cycle as the new `o_level`.
- Read clear: `pending` reads 0 in the cycle after the `i_rd` edge, unless the bit was re-set on that edge.
- Bits are fully independent. Simultaneous transitions on several pins are each handled normally.

## Structure
- Shared package `io_pkg` holds `DATA_WIDTH`=16 (core bus width) and `CLK_HZ`=16_000_000.
- Sub-module `debounce_bit` contains the synchroniser, counter, and `stable`/rise logic, with ports `i_clk`, `i_rst`, `i_pin`, `o_level`, `o_rise`. It is instantiated `WIDTH` times by a generate loop.
- `input_port` owns the pending register, read-clear logic, and `o_data` packing.

## Test plan
Benches use `WIDTH`=3 and `DEBOUNCE_CYCLES`=4.
- Reset, then `i_pins`=3'b000 idle: `o_data`=16'h0000, `o_pending`=0.
- Clean step on pin 0 from 0 to 1 at cycle 0: `o_level`=3'b001 from cycle 6 with `o_rise`=3'b001 for exactly that cycle. `o_data`=16'h0009 and `o_pending`=1.
- Glitch on pin 1: 3 cycles high, then low: `o_level[1]` stays 0, no `o_rise` pulse, pending stays 0. A following 4-cycle high is accepted.
- Read-clear: with `o_data`=16'h0009, pulse `i_rd`: the next cycle shows `o_data`=16'h0001 and `o_pending`=0.
- Simultaneous set and clear: time pin 2's accepted rise to land on the `i_rd` edge. Afterwards `pending`=3'b100, `o_data`=16'h0025 with pin 0 still high, and the set is not lost.
- Async reset mid-count, 2 cycles into a pin 0 change: all outputs are 0 immediately. After release, a full 2+4 cycles is needed for acceptance.
